// File: rtl/mux_2_1_arbiter_if.sv
// rtl/mux_2_1_arbiter_if.sv - requester, downstream and select signals of the 2:1 mux arbiter
// MUX_ARB_STATS_EN adds the per-requester beat counters a_beats/b_beats.
interface mux_2_1_arbiter_if #(
  parameter int DATA_W = 8
);
  logic              a_valid;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              sel;
  logic              busy;
`ifdef MUX_ARB_STATS_EN
  logic [15:0]       a_beats;
  logic [15:0]       b_beats;

  modport slave (
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, out_valid, out_data, sel, busy, a_beats, b_beats
  );
  modport master (
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, out_valid, out_data, sel, busy, a_beats, b_beats
  );
`else
  modport slave (
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, out_valid, out_data, sel, busy
  );
  modport master (
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, out_valid, out_data, sel, busy
  );
`endif
endinterface

// File: rtl/mux_2_1_arbiter.sv
// rtl/mux_2_1_arbiter.sv - round-robin burst arbiter owning the select of a 2:1 data mux
// MUX_ARB_STATS_EN adds saturating per-requester transfer counters.
module mux_2_1_arbiter #(
  parameter int DATA_W   = 8,
  parameter int HOLD_MAX = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  mux_2_1_arbiter_if.slave        arb_if
);

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

  localparam logic [3:0] LAST_BEAT = 4'(HOLD_MAX - 1);
  localparam logic       OWNER_A   = 1'b0;
  localparam logic       OWNER_B   = 1'b1;

  state_t      state_q, state_d;
  logic        sel_q, sel_d;
  logic        last_q, last_d;
  logic [3:0]  cnt_q, cnt_d;

  logic              a_ready;
  logic              b_ready;
  logic              out_valid;
  logic [DATA_W-1:0] mux_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      last_q  <= OWNER_B;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        // A wins a tie only when B owned the previous grant
        if (arb_if.a_valid && (!arb_if.b_valid || last_q == OWNER_B)) begin
          state_d = GRANT_A;
          sel_d   = 1'b0;
          cnt_d   = 4'd0;
        end else if (arb_if.b_valid) begin
          state_d = GRANT_B;
          sel_d   = 1'b1;
          cnt_d   = 4'd0;
        end
      end
      GRANT_A: begin
        out_valid = arb_if.a_valid;
        a_ready   = arb_if.out_ready;
        if (arb_if.a_valid && arb_if.out_ready) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = IDLE;
            last_d  = OWNER_A;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else if (!arb_if.a_valid) begin
          state_d = IDLE;
          last_d  = OWNER_A;
          cnt_d   = 4'd0;
        end
      end
      GRANT_B: begin
        out_valid = arb_if.b_valid;
        b_ready   = arb_if.out_ready;
        if (arb_if.b_valid && arb_if.out_ready) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = IDLE;
            last_d  = OWNER_B;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else if (!arb_if.b_valid) begin
          state_d = IDLE;
          last_d  = OWNER_B;
          cnt_d   = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mux_data         = sel_q ? arb_if.b_data : arb_if.a_data;
  assign arb_if.out_data  = mux_data;
  assign arb_if.out_valid = out_valid;
  assign arb_if.a_ready   = a_ready;
  assign arb_if.b_ready   = b_ready;
  assign arb_if.sel       = sel_q;
  assign arb_if.busy      = (state_q != IDLE);

`ifdef MUX_ARB_STATS_EN
  logic [15:0] a_beats_q, b_beats_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_beats_q <= 16'd0;
      b_beats_q <= 16'd0;
    end else begin
      if (arb_if.a_valid && a_ready && a_beats_q != 16'hFFFF) a_beats_q <= a_beats_q + 16'd1;
      if (arb_if.b_valid && b_ready && b_beats_q != 16'hFFFF) b_beats_q <= b_beats_q + 16'd1;
    end
  end

  assign arb_if.a_beats = a_beats_q;
  assign arb_if.b_beats = b_beats_q;
`endif

endmodule

// File: tb/tb_mux_2_1_arbiter.sv
// tb/tb_mux_2_1_arbiter.sv - directed bench with a burst-level reference model for mux_2_1_arbiter
module tb_mux_2_1_arbiter;
  localparam int DATA_W   = 8;
  localparam int HOLD_MAX = 4;

  logic clk;
  logic rst_n;
  mux_2_1_arbiter_if #(.DATA_W(DATA_W)) bus ();

  mux_2_1_arbiter #(.DATA_W(DATA_W), .HOLD_MAX(HOLD_MAX)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .arb_if (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Sources: each requester offers beats 0xA0+n / 0xB0+n until its quota is reached
  bit a_en, b_en, out_rdy;
  int a_sent = 0, b_sent = 0, a_quota = 0, b_quota = 0;
  bit a_fire, b_fire;

  assign bus.a_valid   = a_en && (a_sent < a_quota);
  assign bus.b_valid   = b_en && (b_sent < b_quota);
  assign bus.a_data    = 8'hA0 + 8'(a_sent);
  assign bus.b_data    = 8'hB0 + 8'(b_sent);
  assign bus.out_ready = out_rdy;

  always @(negedge clk) begin
    a_fire = bus.a_valid && bus.a_ready;
    b_fire = bus.b_valid && bus.b_ready;
  end

  always @(posedge clk) begin
    #1;
    if (a_fire) a_sent++;
    if (b_fire) b_sent++;
    a_fire = 0;
    b_fire = 0;
  end

  // Reference model: who owns the mux, beats moved in this grant, who is favoured next
  int m_owner;
  int m_beats;
  bit m_prefer_b;
  bit m_sel;
  int m_a_cnt, m_b_cnt;
  logic [7:0] m_log[$];
  bit m_v;
  logic [7:0] m_d;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = 0; m_beats = 0; m_prefer_b = 0; m_sel = 0; m_a_cnt = 0; m_b_cnt = 0;
    end else if (m_owner == 0) begin
      if (bus.a_valid && !(bus.b_valid && m_prefer_b)) begin
        m_owner = 1; m_sel = 0; m_beats = 0;
      end else if (bus.b_valid) begin
        m_owner = 2; m_sel = 1; m_beats = 0;
      end
    end else begin
      m_v = (m_owner == 1) ? bus.a_valid : bus.b_valid;
      m_d = (m_owner == 1) ? bus.a_data : bus.b_data;
      if (m_v && out_rdy) begin
        m_log.push_back(m_d);
        m_beats++;
        if (m_owner == 1 && m_a_cnt < 65535) m_a_cnt++;
        if (m_owner == 2 && m_b_cnt < 65535) m_b_cnt++;
        if (m_beats == HOLD_MAX) begin
          m_prefer_b = (m_owner == 1);
          m_owner = 0;
        end
      end else if (!m_v) begin
        m_prefer_b = (m_owner == 1);
        m_owner = 0;
      end
    end
  end

  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("out_valid", bus.out_valid,
          m_owner == 1 ? bus.a_valid : (m_owner == 2 ? bus.b_valid : 1'b0));
      chk("a_ready", bus.a_ready, (m_owner == 1) && out_rdy);
      chk("b_ready", bus.b_ready, (m_owner == 2) && out_rdy);
      chk("busy", bus.busy, m_owner != 0);
      chk("sel", bus.sel, m_sel);
      if (bus.out_valid && m_owner != 0)
        chk("out_data", bus.out_data, m_owner == 1 ? bus.a_data : bus.b_data);
`ifdef MUX_ARB_STATS_EN
      chk("a_beats", bus.a_beats, m_a_cnt);
      chk("b_beats", bus.b_beats, m_b_cnt);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  bit a_ready_seen;

  initial begin
    a_en = 0; b_en = 0; out_rdy = 1;
    rst_n = 1;
    #1 rst_n = 0;
    #1 cmp_en = 1;

    // reset held with both requesters valid
    a_en = 1; b_en = 1; a_quota = 8; b_quota = 4;
    repeat (3) cyc();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_sel", bus.sel, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1;
    cyc();
    chk("first_grant_busy", bus.busy, 1);
    chk("first_grant_sel", bus.sel, 0);
    chk("first_grant_a_ready", bus.a_ready, 1);

    // alternating bursts: A0..A3, B0..B3, A4..A7
    repeat (20) cyc();
    chk("rr_log_size", m_log.size(), 12);
    for (int i = 0; i < 12 && i < m_log.size(); i++)
      chk("rr_log", m_log[i], i < 4 ? 8'hA0 + i : (i < 8 ? 8'hB0 + i - 4 : 8'hA4 + i - 8));
    m_log.delete();

    // B alone for 10 beats
    a_en = 0; b_quota = b_sent + 10; a_ready_seen = 0;
    repeat (20) begin
      cyc();
      if (bus.a_ready) a_ready_seen = 1;
    end
    chk("b_only_a_ready_seen", a_ready_seen, 0);
    chk("b_only_log_size", m_log.size(), 10);
    if (m_log.size() == 10) begin
      chk("b_only_first", m_log[0], 8'hB4);
      chk("b_only_last", m_log[9], 8'hBD);
    end
    m_log.delete();

    // backpressure for 3 cycles after two beats
    a_en = 1; b_en = 0; a_quota = a_sent + 4;
    repeat (3) cyc();
    out_rdy = 0;
    repeat (3) begin
      cyc();
      chk("stall_out_data", bus.out_data, 8'hAA);
      chk("stall_out_valid", bus.out_valid, 1);
    end
    out_rdy = 1;
    repeat (4) cyc();
    chk("stall_log_size", m_log.size(), 4);
    if (m_log.size() == 4) chk("stall_last", m_log[3], 8'hAB);
    chk("stall_busy_after", bus.busy, 0);
    m_log.delete();

    // A drops valid after two beats while B waits
    a_quota = a_sent + 2;
    cyc();
    b_en = 1; b_quota = b_sent + 2;
    chk("drop_grant_sel", bus.sel, 0);
    repeat (3) cyc();
    chk("drop_idle_busy", bus.busy, 0);
    chk("drop_idle_out_valid", bus.out_valid, 0);
    cyc();
    chk("drop_b_busy", bus.busy, 1);
    chk("drop_b_sel", bus.sel, 1);
    chk("drop_b_ready", bus.b_ready, 1);
    repeat (5) cyc();
    chk("drop_log_size", m_log.size(), 4);
    if (m_log.size() == 4) chk("drop_b_first", m_log[2], 8'hBE);
`ifdef MUX_ARB_STATS_EN
    chk("stats_a", bus.a_beats, 14);
    chk("stats_b", bus.b_beats, 16);
`endif

    // asynchronous reset in the middle of an A burst
    b_en = 0; a_quota = a_sent + 3;
    repeat (2) cyc();
    rst_n = 0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_a_ready", bus.a_ready, 0);
    chk("midrst_sel", bus.sel, 0);
`ifdef MUX_ARB_STATS_EN
    chk("midrst_stats_a", bus.a_beats, 0);
    chk("midrst_stats_b", bus.b_beats, 0);
`endif
    repeat (2) cyc();
    rst_n = 1;
    repeat (6) cyc();
    chk("midrst_a_sent", a_sent, 17);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
